ivl_uvm_ovl_window_resp: RTL

Responder side of the OVL window handshake: reacts to an initiator's `req` (`start_event`) by holding `ack` (`test_expr`) high for a programmable window and pulsing `resp` (`end_event`) at its end. It drives an `ovl_window` checker in IVL/UVM OVL benches. It supports deliberate one-cycle `ack` drops so the same bench can produce both pass and fail checker outcomes. It also keeps completed-window and injected-fault counters for scoreboarding.

---
 rtl/ivl_uvm_ovl_window_pkg.sv | 12 +
 rtl/ivl_uvm_ovl_sat_cnt.sv | 31 +++
 rtl/ivl_uvm_ovl_window_resp.sv | 113 +++++++++++
 3 files changed

// File: rtl/ivl_uvm_ovl_window_pkg.sv
// Shared types and default widths for the OVL window responder.
package ivl_uvm_ovl_window_pkg;

  typedef enum logic {
    WIN_IDLE = 1'b0,
    WIN_OPEN = 1'b1
  } win_state_e;

  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/ivl_uvm_ovl_sat_cnt.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module ivl_uvm_ovl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ivl_uvm_ovl_window_resp.sv
// Responder for the OVL window handshake: holds ack for a programmable window
// after req, pulses resp at its end, and can inject a one-cycle ack drop.
module ivl_uvm_ovl_window_resp
  import ivl_uvm_ovl_window_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req,
  input  logic [LEN_W-1:0] win_len,
  input  logic [LEN_W-1:0] drop_at,
  output logic             ack,
  output logic             resp,
  output logic             busy,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  win_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] drop_q, drop_d;
  logic             ack_q, ack_d;
  logic             resp_q, resp_d;
  logic             busy_q, busy_d;
  logic             start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    drop_d  = drop_q;
    start   = 1'b0;

    case (state_q)
      WIN_IDLE: begin
        if (enable && req) begin
          start = 1'b1;
        end
      end
      WIN_OPEN: begin
        if (!enable) begin
          state_d = WIN_IDLE;
        end else if (cnt_q == len_q) begin
          // A req on the last cycle restarts without an ack gap.
          if (req) begin
            start = 1'b1;
          end else begin
            state_d = WIN_IDLE;
          end
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = WIN_IDLE;
    endcase

    if (start) begin
      state_d = WIN_OPEN;
      cnt_d   = LEN_W'(1);
      len_d   = (win_len == '0) ? LEN_W'(1) : win_len;
      drop_d  = drop_at;
    end

    // Outputs are computed from the next-cycle state so they come straight off flops.
    busy_d = (state_d == WIN_OPEN);
    ack_d  = busy_d && (cnt_d != drop_d);
    resp_d = busy_d && (cnt_d == len_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WIN_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      drop_q  <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign resp = resp_q;
  assign busy = busy_q;

  // Counters track the cycles actually presented on the outputs.
  ivl_uvm_ovl_sat_cnt #(.W(CNT_W)) u_win_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (resp_q),
    .cnt   (win_cnt)
  );

  ivl_uvm_ovl_sat_cnt #(.W(CNT_W)) u_fault_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (busy_q && !ack_q),
    .cnt   (fault_cnt)
  );

endmodule
